// File: rtl/fir_out_decimator.sv
// ---------------------------------------------------------------------------
// fir_out_decimator
//
// Output stage for the 63-tap FIR filter. It keeps one of every DECIM valid
// accumulator samples. Each kept sample is rounded, shifted right by SHIFT and
// saturated to 16-bit signed. The result is registered once, then written
// into a small first-word-fall-through FIFO that drains over valid/ready.
//
// Parameters
//   DECIM       decimation ratio, 1..16 (1 keeps every sample)
//   SHIFT       right shift applied to y_in, 1..8
//   FIFO_DEPTH  output FIFO entries, power of two, 2..32
//
// Ports
//   clk         rising-edge clock
//   rst_p       synchronous active-high reset
//   y_in        24-bit signed filter output sample
//   y_valid     y_in carries a new sample this cycle
//   dout        signed sample at the FIFO head, 0 when the FIFO is empty
//   dout_valid  FIFO is non-empty
//   dout_ready  consumer takes dout this cycle
//   level       current FIFO occupancy, 0..FIFO_DEPTH
//   sat_cnt     number of kept samples that clipped, holds at 16'hFFFF
//   ovf         sticky flag: a sample was dropped on a full FIFO
// ---------------------------------------------------------------------------
module fir_out_decimator #(
  parameter int DECIM      = 4,
  parameter int SHIFT      = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_p,
  input  logic [23:0]                 y_in,
  input  logic                        y_valid,
  output logic [15:0]                 dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic [15:0]                 sat_cnt,
  output logic                        ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CW-1:0]      PH_LAST  = CW'(DECIM - 1);
  localparam logic signed [24:0] RND      = 25'sd1 <<< (SHIFT - 1);
  localparam logic signed [24:0] MAXV     = 25'sd32767;
  localparam logic signed [24:0] MINV     = -25'sd32768;
  localparam logic [LW-1:0]      FULL_LVL = LW'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CW-1:0] ph_q, ph_d;
  logic          s_valid_q, s_valid_d;
  logic [15:0]   s_data_q, s_data_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   sat_cnt_q, sat_cnt_d;
  logic          ovf_q, ovf_d;

  logic [15:0]   mem_q [FIFO_DEPTH];

  // -------------------------------------------------------------------------
  // Scaling: one extra bit of headroom so the rounding add cannot wrap.
  // -------------------------------------------------------------------------
  logic signed [24:0] t_w;
  logic signed [24:0] r_w;
  logic               clip_hi_w;
  logic               clip_lo_w;
  logic [15:0]        scaled_w;

  always_comb begin
    t_w       = $signed({y_in[23], y_in}) + RND;
    r_w       = t_w >>> SHIFT;
    clip_hi_w = (r_w > MAXV);
    clip_lo_w = (r_w < MINV);
    if (clip_hi_w) begin
      scaled_w = 16'h7FFF;
    end else if (clip_lo_w) begin
      scaled_w = 16'h8000;
    end else begin
      scaled_w = r_w[15:0];
    end
  end

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic keep_w;
  logic empty_w;
  logic full_w;
  logic pop_w;
  logic push_w;
  logic drop_w;

  always_comb begin
    keep_w  = y_valid && (ph_q == '0);
    empty_w = (level_q == '0);
    full_w  = (level_q == FULL_LVL);
    pop_w   = !empty_w && dout_ready;
    // A full FIFO can still accept the sample when the head leaves this cycle.
    push_w  = s_valid_q && (!full_w || pop_w);
    drop_w  = s_valid_q && full_w && !pop_w;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    ph_d      = ph_q;
    s_valid_d = keep_w;
    s_data_d  = scaled_w;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    sat_cnt_d = sat_cnt_q;
    ovf_d     = ovf_q;

    if (y_valid) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + CW'(1);
    end

    if (keep_w && (clip_hi_w || clip_lo_w) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end

    // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH naturally.
    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_w, pop_w})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop_w) begin
      ovf_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_p) begin
      ph_q      <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sat_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sat_cnt_q <= sat_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset: an empty level makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= s_data_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: head of FIFO is read combinationally (fall-through).
  // -------------------------------------------------------------------------
  always_comb begin
    dout_valid = !empty_w;
    dout       = empty_w ? 16'h0000 : mem_q[rd_ptr_q];
    level      = level_q;
    sat_cnt    = sat_cnt_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_fir_out_decimator.sv
// ---------------------------------------------------------------------------
// Testbench for fir_out_decimator. Three instances cover DECIM = 4, 1 and 3
// (SHIFT = 7, FIFO_DEPTH = 8). Expected samples are pushed to a per-instance
// queue when stimulus is driven and compared as the DUT hands them out.
// ---------------------------------------------------------------------------
module tb_fir_out_decimator;

  localparam int SHIFT = 7;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_p = 1'b1;

  logic [23:0] y4 = '0, y1 = '0, y3 = '0;
  logic        yv4 = 1'b0, yv1 = 1'b0, yv3 = 1'b0;
  logic        rdy4 = 1'b1, rdy1 = 1'b0, rdy3 = 1'b1;
  logic [15:0] dout4, dout1, dout3;
  logic        dv4, dv1, dv3;
  logic [3:0]  lvl4, lvl1, lvl3;
  logic [15:0] sat4, sat1, sat3;
  logic        ovf4, ovf1, ovf3;

  int n_cmp = 0;
  int n_err = 0;

  int ph4 = 0, ph1 = 0, ph3 = 0;
  int sat4_exp = 0;

  logic [15:0] q4[$];
  logic [15:0] q1[$];
  logic [15:0] q3[$];

  logic signed [31:0] e4, e1, e3;

  always #5 clk = ~clk;

  fir_out_decimator #(.DECIM(4), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) u4 (
    .clk(clk), .rst_p(rst_p), .y_in(y4), .y_valid(yv4),
    .dout(dout4), .dout_valid(dv4), .dout_ready(rdy4),
    .level(lvl4), .sat_cnt(sat4), .ovf(ovf4)
  );

  fir_out_decimator #(.DECIM(1), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst_p(rst_p), .y_in(y1), .y_valid(yv1),
    .dout(dout1), .dout_valid(dv1), .dout_ready(rdy1),
    .level(lvl1), .sat_cnt(sat1), .ovf(ovf1)
  );

  fir_out_decimator #(.DECIM(3), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) u3 (
    .clk(clk), .rst_p(rst_p), .y_in(y3), .y_valid(yv3),
    .dout(dout3), .dout_valid(dv3), .dout_ready(rdy3),
    .level(lvl3), .sat_cnt(sat3), .ovf(ovf3)
  );

  // Reference scaling: round half up by floor division, then clip.
  function automatic logic [15:0] model(input logic [23:0] y, output bit clip);
    longint t, r, dv;
    dv = longint'(1) << SHIFT;
    t  = longint'($signed(y)) + dv / 2;
    if (t >= 0) r = t / dv;
    else        r = -((-t + dv - 1) / dv);
    clip = (r > 32767) || (r < -32768);
    if (r > 32767)       r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on instance u; kept samples go to the scoreboard when
  // store=1 (store=0 marks a sample the FIFO is expected to drop).
  task automatic send(input int u, input logic [23:0] y, input bit v, input bit store);
    logic [15:0] e;
    bit c;
    case (u)
      4: begin
        y4 = y; yv4 = v;
        if (v) begin
          if (ph4 == 0) begin
            e = model(y, c);
            if (store) q4.push_back(e);
            if (c) sat4_exp++;
          end
          ph4 = (ph4 + 1) % 4;
        end
      end
      1: begin
        y1 = y; yv1 = v;
        if (v) begin
          e = model(y, c);
          if (store) q1.push_back(e);
        end
      end
      default: begin
        y3 = y; yv3 = v;
        if (v) begin
          if (ph3 == 0) begin
            e = model(y, c);
            if (store) q3.push_back(e);
          end
          ph3 = (ph3 + 1) % 3;
        end
      end
    endcase
    tick();
    yv4 = 1'b0; yv1 = 1'b0; yv3 = 1'b0;
  endtask

  task automatic drain(input int u);
    int n;
    n = 0;
    case (u)
      4: begin
        while (dv4 && n < 40) begin tick(); n++; end
        check("drain4_dv", 32'(dv4), 0);
        check("q4_left", q4.size(), 0);
      end
      1: begin
        while (dv1 && n < 40) begin tick(); n++; end
        check("drain1_dv", 32'(dv1), 0);
        check("q1_left", q1.size(), 0);
      end
      default: begin
        while (dv3 && n < 40) begin tick(); n++; end
        check("drain3_dv", 32'(dv3), 0);
        check("q3_left", q3.size(), 0);
      end
    endcase
  endtask

  task automatic do_reset(input bit v_during);
    rst_p = 1'b1;
    yv4 = v_during; y4 = 24'd12800;
    tick();
    rst_p = 1'b0;
    yv4 = 1'b0;
    q4.delete(); q1.delete(); q3.delete();
    ph4 = 0; ph1 = 0; ph3 = 0; sat4_exp = 0;
  endtask

  // Output monitors: a transfer happens at the coming edge when valid&&ready.
  always @(negedge clk) begin
    if (!rst_p && dv4 && rdy4) begin
      if (q4.size() > 0) e4 = 32'($signed(q4.pop_front()));
      else               e4 = 32'sh7FFF_FFFF;
      $display("u4 pop dout=%0d exp=%0d", $signed(dout4), e4);
      check("dout4", 32'($signed(dout4)), e4);
    end
  end

  always @(negedge clk) begin
    if (!rst_p && dv1 && rdy1) begin
      if (q1.size() > 0) e1 = 32'($signed(q1.pop_front()));
      else               e1 = 32'sh7FFF_FFFF;
      $display("u1 pop dout=%0d exp=%0d", $signed(dout1), e1);
      check("dout1", 32'($signed(dout1)), e1);
    end
  end

  always @(negedge clk) begin
    if (!rst_p && dv3 && rdy3) begin
      if (q3.size() > 0) e3 = 32'($signed(q3.pop_front()));
      else               e3 = 32'sh7FFF_FFFF;
      $display("u3 pop dout=%0d exp=%0d", $signed(dout3), e3);
      check("dout3", 32'($signed(dout3)), e3);
    end
  end

  initial begin : stim
    logic [23:0] seq1 [8];
    logic [23:0] seq2 [8];
    logic [23:0] pat;
    int n;

    seq1 = '{24'd200, 24'd1, 24'd1, 24'd1, -24'sd200, 24'd1, 24'd1, 24'd1};
    seq2 = '{24'h7FFFFF, 24'd0, 24'd0, 24'd0, 24'h800000, 24'd0, 24'd0, 24'd0};
    pat  = 24'b1011_0111_0100_1101_1001_1001;

    // Power-on reset state
    tick(); tick();
    rst_p = 1'b0;
    check("rst_dv", 32'(dv4), 0);
    check("rst_dout", 32'(dout4), 0);
    check("rst_level", 32'(lvl4), 0);
    check("rst_sat", 32'(sat4), 0);
    check("rst_ovf", 32'(ovf4), 0);

    // Decimate by 4 with rounding; first output two edges after the sample
    for (int i = 0; i < 8; i++) begin
      send(4, seq1[i], 1'b1, 1'b1);
      if (i == 0) check("lat_edge1_dv", 32'(dv4), 0);
      if (i == 1) check("lat_edge2_dv", 32'(dv4), 1);
    end
    drain(4);

    // Saturation at both rails
    for (int i = 0; i < 8; i++) send(4, seq2[i], 1'b1, 1'b1);
    check("sat_cnt2", 32'(sat4), sat4_exp);
    check("sat_cnt2_const", 32'(sat4), 2);
    drain(4);

    // Gapped valid stream, DECIM=3
    for (int i = 0; i < 24; i++) send(3, 24'(i * 3001 - 20000), pat[i], 1'b1);
    drain(3);

    // Overflow: 10 samples into an 8-deep FIFO with the consumer stalled
    rdy1 = 1'b0;
    for (int k = 1; k <= 10; k++) send(1, 24'(k * 128), 1'b1, k <= 8);
    tick();
    check("ovf_level", 32'(lvl1), 8);
    check("ovf_flag", 32'(ovf1), 1);
    check("stall_dout_a", 32'($signed(dout1)), 1);
    tick(); tick();
    check("stall_dout_b", 32'($signed(dout1)), 1);
    check("stall_dv", 32'(dv1), 1);
    rdy1 = 1'b1;
    n = 0;
    while (dv1 && n < 20) begin tick(); n++; end
    check("pops_until_empty", n, 8);
    check("empty_dout", 32'(dout1), 0);
    check("q1_left_ovf", q1.size(), 0);

    do_reset(1'b0);

    // Full FIFO with a push and a pop every cycle
    rdy1 = 1'b0;
    for (int k = 11; k <= 19; k++) send(1, 24'(k * 128), 1'b1, 1'b1);
    check("full_level", 32'(lvl1), 8);
    rdy1 = 1'b1;
    for (int k = 20; k <= 31; k++) begin
      send(1, 24'(k * 128), 1'b1, 1'b1);
      check("steady_level", 32'(lvl1), 8);
    end
    check("steady_ovf", 32'(ovf1), 0);
    drain(1);

    // Reset with 5 entries buffered and a sample in S
    rdy4 = 1'b0;
    for (int i = 1; i <= 21; i++) send(4, 24'(i * 640), 1'b1, 1'b1);
    check("pre_rst_level", 32'(lvl4), 5);
    do_reset(1'b1);
    check("mid_rst_dv", 32'(dv4), 0);
    check("mid_rst_dout", 32'(dout4), 0);
    check("mid_rst_level", 32'(lvl4), 0);
    check("mid_rst_sat", 32'(sat4), 0);
    check("mid_rst_ovf", 32'(ovf4), 0);
    tick();
    check("post_rst_level", 32'(lvl4), 0);
    rdy4 = 1'b1;
    send(4, 24'd384, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(4, 24'd1000, 1'b1, 1'b1);
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
